riscv_multicycle_ctrl: RTL and testbench
========================================

// Module: riscv_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the next-generation RV32I core. Replaces the single-cycle
//  control unit: one instruction takes 3-5 states over a shared instruction/data memory.
//  Adds a memory ready handshake, illegal-opcode trap and retired-instruction counter.
//  Sits between the instruction register fields and the datapath muxes, register file and memory.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: memory states wait on mem_ready; 0: mem_ready ignored (treated as 1)
//  TRAP_ILLEGAL   1   1: unknown opcode -> TRAP (halt); 0: unknown opcode retired as NOP
//  CNT_W          32  width of instret counter
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  Opcode       in   7      instr[6:0] from instruction register
//  func3        in   3      instr[14:12]
//  func7b5      in   1      instr[30]
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory access completes this cycle
//  PCWrite      out  1      PC register load enable
//  AdrSrc       out  1      memory address: 0=PC, 1=ALUOut
//  MemWrite     out  1      data memory write strobe
//  IRWrite      out  1      instruction/OldPC register load enable
//  ResultSrc    out  2      00=ALUOut, 01=Data reg, 10=ALUResult
//  ALUSrcA      out  2      00=PC, 01=OldPC, 10=reg A
//  ALUSrcB      out  2      00=reg B, 01=imm, 10=const 4
//  ALUControl   out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc       out  2      00=I, 01=S, 10=B, 11=J
//  RegWrite     out  1      register file write enable
//  halted       out  1      core in TRAP
//  instret      out  CNT_W  retired instruction count
// BEHAVIOUR
//  States: FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI ALUWB BEQ JAL TRAP.
//  Outputs are Moore (state) except PCWrite/IRWrite (gated by mem_ready, zero); unlisted = 0.
//  FETCH: AdrSrc=0,ALUSrcA=00,ALUSrcB=10,add,ResultSrc=10; IRWrite=PCWrite=mem_ready;
//    stay while !mem_ready, else -> DECODE.
//  DECODE: ALUSrcA=01,ALUSrcB=01,add (branch target). ImmSrc from Opcode in every state:
//    0000011/0010011 I, 0100011 S, 1100011 B, 1101111 J, else 00.
//    lw/sw -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL;
//    other -> TRAP if TRAP_ILLEGAL else FETCH (counted as retired).
//  MEMADR: ALUSrcA=10,ALUSrcB=01,add; lw -> MEMREAD, sw -> MEMWRITE.
//  MEMREAD: AdrSrc=1; wait on mem_ready, then -> MEMWB.  MEMWB: ResultSrc=01,RegWrite=1 -> FETCH.
//  MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until mem_ready; then -> FETCH.
//  EXECR: ALUSrcA=10,ALUSrcB=00,func decode. EXECI: ALUSrcA=10,ALUSrcB=01,func decode. Both -> ALUWB.
//  Func decode: func3 000 -> sub if EXECR & func7b5 else add; 010 slt; 110 or; 111 and; other add.
//  ALUWB: ResultSrc=00,RegWrite=1 -> FETCH.
//  BEQ: ALUSrcA=10,ALUSrcB=00,sub,ResultSrc=00; PCWrite=zero -> FETCH.
//  JAL: ALUSrcA=01,ALUSrcB=10,add,ResultSrc=00,PCWrite=1 -> ALUWB (rd=PC+4).
//  TRAP: all strobes 0, halted=1, absorbing until reset.
//  instret: +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BEQ or DECODE(NOP);
//    wraps modulo 2^CNT_W; never increments in TRAP.
//  MEM_HANDSHAKE=0: FETCH/MEMREAD/MEMWRITE each last exactly 1 cycle.
//  Latency (mem_ready=1): beq 3, sw/R/I 4, jal 4, lw 5 cycles.
//  Reset (reset=0, async): state=FETCH, instret=0, halted=0; PCWrite, IRWrite, MemWrite,
//    RegWrite forced 0 while reset low; mux selects show FETCH values. Reset mid-instruction
//    aborts it with no strobe; first FETCH occurs on first clock edge after reset releases.
// TESTING
//  Reset released, mem_ready=1, lw (0000011) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite only in MEMWB; instret=1.
//  sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, no extra PCWrite, instret+1 once.
//  R-type func3=000 func7b5=1 -> ALUControl=001 in EXECR; func3=111 -> 010; I-type func7b5=1 -> 000.
//  beq zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; both 3 cycles, instret+1.
//  Opcode 1111111: TRAP_ILLEGAL=1 -> halted=1, strobes 0 forever; =0 -> FETCH next, instret+1.
//  reset low in MEMWRITE with MemWrite=1 -> MemWrite=0 immediately; CNT_W=4 16 retires -> instret wraps to 0.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Multi-cycle RV32I control FSM. Each instruction walks FETCH -> DECODE -> one or
// more execute/memory states -> back to FETCH, sharing one memory port for
// instructions and data. Adds a memory ready handshake, an illegal-opcode trap and
// a retired-instruction counter.
//
// Memory handshake: the FSM raises a request by entering FETCH, MEMREAD or MEMWRITE
// and holds AdrSrc (and MemWrite in MEMWRITE) stable every cycle until mem_ready is
// high; the access completes in the cycle mem_ready is sampled high, and the FSM
// leaves the state on that clock edge. With MEM_HANDSHAKE=0 mem_ready is ignored
// and each memory state lasts exactly one cycle.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned TRAP_ILLEGAL  = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       func3,
    input  logic             func7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic HANDSHAKE_ON = (MEM_HANDSHAKE != 0);
    localparam logic TRAP_ON      = (TRAP_ILLEGAL != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    logic       mem_ok;
    logic       retire;
    logic [2:0] alu_func;
    logic       pcwrite_c, irwrite_c, memwrite_c, regwrite_c;

    // Without the handshake every memory access is assumed to finish in one cycle.
    assign mem_ok = HANDSHAKE_ON ? mem_ready : 1'b1;

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (Opcode)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    // ALU function from func3; subtract only for R-type with func7b5 set.
    always_comb begin
        alu_func = ALU_ADD;
        case (func3)
            3'b000:  alu_func = ((state_q == S_EXECR) && func7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_func = ALU_SLT;
            3'b110:  alu_func = ALU_OR;
            3'b111:  alu_func = ALU_AND;
            default: alu_func = ALU_ADD;
        endcase
    end

    // Next-state and Moore outputs; PCWrite/IRWrite also depend on mem_ready and zero.
    always_comb begin
        state_d    = state_q;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irwrite_c = mem_ok;
                pcwrite_c = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = TRAP_ON ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_func;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_func;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                pcwrite_c  = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // An instruction retires when its last state hands control back to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                     (state_q == S_DECODE));

    assign instret_d = retire ? (instret_q + {{(CNT_W-1){1'b0}}, 1'b1}) : instret_q;

    // State and retire counter registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Strobes are suppressed while reset is held so an aborted access never writes.
    assign PCWrite   = pcwrite_c  & reset;
    assign IRWrite   = irwrite_c  & reset;
    assign MemWrite  = memwrite_c & reset;
    assign RegWrite  = regwrite_c & reset;
    assign halted    = (state_q == S_TRAP);
    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl. Three instances: default parameters (a),
// TRAP_ILLEGAL=0 with a 4-bit counter (b), and MEM_HANDSHAKE=0 (c). Control outputs
// are packed as {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
// ALUControl,ImmSrc,RegWrite} and compared against hand-written words.
module tb_riscv_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clock = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b5, zero, mem_ready;

    logic        pcw_a, adr_a, mw_a, irw_a, rw_a, halted_a;
    logic [1:0]  rs_a, sa_a, sb_a, imm_a;
    logic [2:0]  alu_a;
    logic [31:0] instret_a;
    logic [3:0]  state_a;

    logic        pcw_b, adr_b, mw_b, irw_b, rw_b, halted_b;
    logic [1:0]  rs_b, sa_b, sb_b, imm_b;
    logic [2:0]  alu_b;
    logic [3:0]  instret_b;
    logic [3:0]  state_b;

    logic        pcw_c, adr_c, mw_c, irw_c, rw_c, halted_c;
    logic [1:0]  rs_c, sa_c, sb_c, imm_c;
    logic [2:0]  alu_c;
    logic [31:0] instret_c;
    logic [3:0]  state_c;

    logic [15:0] ctrl_a, ctrl_b, ctrl_c;
    assign ctrl_a = {pcw_a, adr_a, mw_a, irw_a, rs_a, sa_a, sb_a, alu_a, imm_a, rw_a};
    assign ctrl_b = {pcw_b, adr_b, mw_b, irw_b, rs_b, sa_b, sb_b, alu_b, imm_b, rw_b};
    assign ctrl_c = {pcw_c, adr_c, mw_c, irw_c, rs_c, sa_c, sb_c, alu_c, imm_c, rw_c};

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_ret_a = 32'd0;

    riscv_multicycle_ctrl dut_a (
        .clock(clock), .reset(rst_a), .Opcode(opcode), .func3(func3), .func7b5(func7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw_a), .AdrSrc(adr_a),
        .MemWrite(mw_a), .IRWrite(irw_a), .ResultSrc(rs_a), .ALUSrcA(sa_a),
        .ALUSrcB(sb_a), .ALUControl(alu_a), .ImmSrc(imm_a), .RegWrite(rw_a),
        .halted(halted_a), .instret(instret_a), .dbg_state(state_a)
    );

    riscv_multicycle_ctrl #(.MEM_HANDSHAKE(1), .TRAP_ILLEGAL(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(rst_b), .Opcode(opcode), .func3(func3), .func7b5(func7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw_b), .AdrSrc(adr_b),
        .MemWrite(mw_b), .IRWrite(irw_b), .ResultSrc(rs_b), .ALUSrcA(sa_b),
        .ALUSrcB(sb_b), .ALUControl(alu_b), .ImmSrc(imm_b), .RegWrite(rw_b),
        .halted(halted_b), .instret(instret_b), .dbg_state(state_b)
    );

    riscv_multicycle_ctrl #(.MEM_HANDSHAKE(0), .TRAP_ILLEGAL(1), .CNT_W(32)) dut_c (
        .clock(clock), .reset(rst_c), .Opcode(opcode), .func3(func3), .func7b5(func7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw_c), .AdrSrc(adr_c),
        .MemWrite(mw_c), .IRWrite(irw_c), .ResultSrc(rs_c), .ALUSrcA(sa_c),
        .ALUSrcB(sb_c), .ALUControl(alu_c), .ImmSrc(imm_c), .RegWrite(rw_c),
        .halted(halted_c), .instret(instret_c), .dbg_state(state_c)
    );

    // Clock: 10 ns period.
    always #5 clock = ~clock;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        opcode = OP_LW; func3 = 3'b000; func7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if (ctrl_a !== 16'b0_0_0_0_10_00_10_000_00_0 || state_a !== 4'd0 ||
            instret_a !== 32'd0 || halted_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a ctrl=%b st=%0d ret=%0d h=%b exp ctrl=0000100010000000 st=0 ret=0 h=0",
                     ctrl_a, state_a, instret_a, halted_a);
        end
        n_vec++;
        if (ctrl_b !== 16'b0_0_0_0_10_00_10_000_00_0 || instret_b !== 4'd0 ||
            ctrl_c !== 16'b0_0_0_0_10_00_10_000_00_0 || instret_c !== 32'd0) begin
            n_err++;
            $display("FAIL reset_bc ctrl_b=%b ret_b=%0d ctrl_c=%b ret_c=%0d exp 0000100010000000/0",
                     ctrl_b, instret_b, ctrl_c, instret_c);
        end
        rst_a = 1'b1;
    endtask

    task automatic test_lw();
        logic [15:0] ec [5];
        logic [3:0]  es [5];
        ec = '{16'b1_0_0_1_10_00_10_000_00_0, 16'b0_0_0_0_00_01_01_000_00_0,
               16'b0_0_0_0_00_10_01_000_00_0, 16'b0_1_0_0_00_00_00_000_00_0,
               16'b0_0_0_0_01_00_00_000_00_1};
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (ctrl_a !== ec[i] || state_a !== es[i]) begin
                n_err++;
                $display("FAIL lw cyc%0d ctrl=%b st=%0d exp ctrl=%b st=%0d", i, ctrl_a, state_a, ec[i], es[i]);
            end
            tick();
        end
        exp_ret_a++;
        n_vec++;
        if (state_a !== 4'd0 || instret_a !== exp_ret_a) begin
            n_err++;
            $display("FAIL lw_retire st=%0d ret=%0d exp st=0 ret=%0d", state_a, instret_a, exp_ret_a);
        end
    endtask

    task automatic test_sw_wait();
        logic [15:0] ec [8];
        logic [3:0]  es [8];
        logic        mr [8];
        ec = '{16'b0_0_0_0_10_00_10_000_01_0, 16'b1_0_0_1_10_00_10_000_01_0,
               16'b0_0_0_0_00_01_01_000_01_0, 16'b0_0_0_0_00_10_01_000_01_0,
               16'b0_1_1_0_00_00_00_000_01_0, 16'b0_1_1_0_00_00_00_000_01_0,
               16'b0_1_1_0_00_00_00_000_01_0, 16'b0_1_1_0_00_00_00_000_01_0};
        es = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
        mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OP_SW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            n_vec++;
            if (ctrl_a !== ec[i] || state_a !== es[i] || instret_a !== exp_ret_a) begin
                n_err++;
                $display("FAIL sw_wait cyc%0d ctrl=%b st=%0d ret=%0d exp ctrl=%b st=%0d ret=%0d",
                         i, ctrl_a, state_a, instret_a, ec[i], es[i], exp_ret_a);
            end
            tick();
        end
        exp_ret_a++;
        n_vec++;
        if (state_a !== 4'd0 || instret_a !== exp_ret_a) begin
            n_err++;
            $display("FAIL sw_retire st=%0d ret=%0d exp st=0 ret=%0d", state_a, instret_a, exp_ret_a);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] op_v  [5];
        logic [2:0] f3_v  [5];
        logic       f7_v  [5];
        logic [2:0] alu_v [5];
        logic [15:0] ec [4];
        logic [3:0]  es [4];
        op_v  = '{OP_R, OP_R, OP_R, OP_I, OP_I};
        f3_v  = '{3'b000, 3'b111, 3'b010, 3'b000, 3'b110};
        f7_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        alu_v = '{3'b001, 3'b010, 3'b101, 3'b000, 3'b011};
        mem_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            opcode = op_v[v]; func3 = f3_v[v]; func7b5 = f7_v[v];
            ec[0] = 16'b1_0_0_1_10_00_10_000_00_0;
            ec[1] = 16'b0_0_0_0_00_01_01_000_00_0;
            ec[2] = {4'b0000, 2'b00, 2'b10, (v < 3) ? 2'b00 : 2'b01, alu_v[v], 2'b00, 1'b0};
            ec[3] = 16'b0_0_0_0_00_00_00_000_00_1;
            es = '{4'd0, 4'd1, (v < 3) ? 4'd6 : 4'd7, 4'd8};
            for (int i = 0; i < 4; i++) begin
                #1;
                n_vec++;
                if (ctrl_a !== ec[i] || state_a !== es[i]) begin
                    n_err++;
                    $display("FAIL alu v%0d cyc%0d ctrl=%b st=%0d exp ctrl=%b st=%0d",
                             v, i, ctrl_a, state_a, ec[i], es[i]);
                end
                tick();
            end
            exp_ret_a++;
            n_vec++;
            if (state_a !== 4'd0 || instret_a !== exp_ret_a) begin
                n_err++;
                $display("FAIL alu_retire v%0d st=%0d ret=%0d exp st=0 ret=%0d", v, state_a, instret_a, exp_ret_a);
            end
        end
        func3 = 3'b000; func7b5 = 1'b0;
    endtask

    task automatic test_beq();
        logic [15:0] ec [3];
        opcode = OP_BEQ; mem_ready = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            ec[0] = 16'b1_0_0_1_10_00_10_000_10_0;
            ec[1] = 16'b0_0_0_0_00_01_01_000_10_0;
            ec[2] = {(z == 1), 15'b0_0_0_00_10_00_001_10_0};
            for (int i = 0; i < 3; i++) begin
                #1;
                n_vec++;
                if (ctrl_a !== ec[i] || state_a !== ((i == 2) ? 4'd9 : 4'(i))) begin
                    n_err++;
                    $display("FAIL beq z%0d cyc%0d ctrl=%b st=%0d exp ctrl=%b", z, i, ctrl_a, state_a, ec[i]);
                end
                tick();
            end
            exp_ret_a++;
            n_vec++;
            if (state_a !== 4'd0 || instret_a !== exp_ret_a) begin
                n_err++;
                $display("FAIL beq_retire z%0d st=%0d ret=%0d exp st=0 ret=%0d", z, state_a, instret_a, exp_ret_a);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [15:0] ec [4];
        logic [3:0]  es [4];
        ec = '{16'b1_0_0_1_10_00_10_000_11_0, 16'b0_0_0_0_00_01_01_000_11_0,
               16'b1_0_0_0_00_01_10_000_11_0, 16'b0_0_0_0_00_00_00_000_11_1};
        es = '{4'd0, 4'd1, 4'd10, 4'd8};
        opcode = OP_JAL; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (ctrl_a !== ec[i] || state_a !== es[i]) begin
                n_err++;
                $display("FAIL jal cyc%0d ctrl=%b st=%0d exp ctrl=%b st=%0d", i, ctrl_a, state_a, ec[i], es[i]);
            end
            tick();
        end
        exp_ret_a++;
        n_vec++;
        if (state_a !== 4'd0 || instret_a !== exp_ret_a) begin
            n_err++;
            $display("FAIL jal_retire st=%0d ret=%0d exp st=0 ret=%0d", state_a, instret_a, exp_ret_a);
        end
    endtask

    task automatic test_trap();
        opcode = OP_BAD; mem_ready = 1'b1; zero = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ctrl_a !== 16'd0 || state_a !== 4'd11 || halted_a !== 1'b1 || instret_a !== exp_ret_a) begin
                n_err++;
                $display("FAIL trap cyc%0d ctrl=%b st=%0d h=%b ret=%0d exp ctrl=0 st=11 h=1 ret=%0d",
                         i, ctrl_a, state_a, halted_a, instret_a, exp_ret_a);
            end
            tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        rst_a = 1'b0;
        #1;
        n_vec++;
        if (halted_a !== 1'b0 || state_a !== 4'd0 || instret_a !== 32'd0) begin
            n_err++;
            $display("FAIL trap_reset h=%b st=%0d ret=%0d exp h=0 st=0 ret=0", halted_a, state_a, instret_a);
        end
        tick();
        rst_a = 1'b1;
        exp_ret_a = 32'd0;
        opcode = OP_SW; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        n_vec++;
        if (mw_a !== 1'b1 || state_a !== 4'd5) begin
            n_err++;
            $display("FAIL mid_write_pre mw=%b st=%0d exp mw=1 st=5", mw_a, state_a);
        end
        rst_a = 1'b0;
        #1;
        n_vec++;
        if (ctrl_a !== 16'b0_0_0_0_10_00_10_000_01_0 || state_a !== 4'd0 || instret_a !== 32'd0) begin
            n_err++;
            $display("FAIL mid_write_abort ctrl=%b st=%0d ret=%0d exp ctrl=0000100010000010 st=0 ret=0",
                     ctrl_a, state_a, instret_a);
        end
        tick();
    endtask

    task automatic test_nop_and_wrap();
        rst_b = 1'b1;
        opcode = OP_BAD; mem_ready = 1'b1; zero = 1'b0;
        tick();
        n_vec++;
        if (state_b !== 4'd1 || ctrl_b !== 16'b0_0_0_0_00_01_01_000_00_0) begin
            n_err++;
            $display("FAIL nop_decode st=%0d ctrl=%b exp st=1 ctrl=0000000101000000", state_b, ctrl_b);
        end
        tick();
        n_vec++;
        if (state_b !== 4'd0 || halted_b !== 1'b0 || instret_b !== 4'd1) begin
            n_err++;
            $display("FAIL nop_retire st=%0d h=%b ret=%0d exp st=0 h=0 ret=1", state_b, halted_b, instret_b);
        end
        opcode = OP_BEQ;
        for (int k = 0; k < 14; k++) begin
            tick(); tick(); tick();
        end
        n_vec++;
        if (instret_b !== 4'd15) begin
            n_err++;
            $display("FAIL wrap_pre ret=%0d exp 15", instret_b);
        end
        tick(); tick(); tick();
        n_vec++;
        if (instret_b !== 4'd0 || state_b !== 4'd0) begin
            n_err++;
            $display("FAIL wrap ret=%0d st=%0d exp ret=0 st=0", instret_b, state_b);
        end
        rst_b = 1'b0;
    endtask

    task automatic test_no_handshake();
        logic [15:0] ec [9];
        logic [3:0]  es [9];
        ec = '{16'b1_0_0_1_10_00_10_000_00_0, 16'b0_0_0_0_00_01_01_000_00_0,
               16'b0_0_0_0_00_10_01_000_00_0, 16'b0_1_0_0_00_00_00_000_00_0,
               16'b0_0_0_0_01_00_00_000_00_1,
               16'b1_0_0_1_10_00_10_000_01_0, 16'b0_0_0_0_00_01_01_000_01_0,
               16'b0_0_0_0_00_10_01_000_01_0, 16'b0_1_1_0_00_00_00_000_01_0};
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd5};
        rst_c = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            opcode = (i < 5) ? OP_LW : OP_SW;
            #1;
            n_vec++;
            if (ctrl_c !== ec[i] || state_c !== es[i]) begin
                n_err++;
                $display("FAIL nohs cyc%0d ctrl=%b st=%0d exp ctrl=%b st=%0d", i, ctrl_c, state_c, ec[i], es[i]);
            end
            tick();
        end
        n_vec++;
        if (state_c !== 4'd0 || instret_c !== 32'd2) begin
            n_err++;
            $display("FAIL nohs_retire st=%0d ret=%0d exp st=0 ret=2", state_c, instret_c);
        end
        rst_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_decode();
        test_beq();
        test_jal();
        test_trap();
        test_reset_mid_write();
        test_nop_and_wrap();
        test_no_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
